// File: rtl/avg_sample_uart_tx.sv
// Buffers filtered samples captured on strobe rising edges and sends each one
// as two UART 8N1 frames: {4'hA, upper bits} then the low byte.
module avg_sample_uart_tx #(
  parameter int DATA_W       = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_strobe,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   byte1_q, byte1_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   tx_q, tx_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]            level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic                   stb_dly_q, stb_dly_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];

  logic capture, empty, full, pop, push, baud_end;

  function automatic logic [7:0] hi_byte(input logic [DATA_W-1:0] s);
    return {4'hA, 4'(s >> 8)};
  endfunction

  assign capture  = sample_strobe & ~stb_dly_q;
  assign empty    = (level_q == '0);
  assign full     = (level_q == (AW+1)'(FIFO_DEPTH));
  assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    byte1_d = byte1_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) pop = 1'b1;
      end
      S_START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (!byte1_q) begin
            shreg_d = 8'(hold_q);
            byte1_d = 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Next sample's header byte goes straight into START, no idle gap.
    if (pop) begin
      hold_d  = mem_q[rd_q];
      shreg_d = hi_byte(mem_q[rd_q]);
      byte1_d = 1'b0;
      baud_d  = '0;
      state_d = S_START;
      tx_d    = 1'b0;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    stb_dly_d = sample_strobe;
    // A full FIFO still accepts a write when the same edge pops an entry.
    push      = capture & (~full | pop);
    ovf_d     = ovf_q | (capture & full & ~pop);
    if (push) begin
      mem_d[wr_q] = sample_in;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      byte1_q   <= 1'b0;
      hold_q    <= '0;
      tx_q      <= 1'b1;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      stb_dly_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      byte1_q   <= byte1_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      stb_dly_q <= stb_dly_d;
    end
    mem_q <= mem_d;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) | (level_q != '0);
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_avg_sample_uart_tx.sv
// Bench for avg_sample_uart_tx: a timeline model predicts tx/busy/level/overflow
// every cycle from capture times; directed sequences decode bytes and corners.
module tb_avg_sample_uart_tx;
  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 20 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strobe = 1'b0;
  logic [DW-1:0] sin = '0;
  logic          tx, busy, ovf;
  logic [2:0]    lvl;

  always #5 clk = ~clk;

  avg_sample_uart_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .sample_in(sin), .sample_strobe(strobe),
    .tx(tx), .busy(busy), .overflow(ovf), .fifo_level(lvl)
  );

  // Accepted sample and the edge at which the transmitter takes it.
  typedef struct { int pop; logic [DW-1:0] s; } ent_t;
  ent_t q[$];
  int   t = 0;
  int   last_pop = -1000000;
  bit   prev_stb = 1'b1;
  bit   m_ovf = 1'b0;
  int   total = 0, bad = 0, peak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  function automatic int mod_level();
    int n = 0;
    foreach (q[i]) if (q[i].pop > t) n++;
    return n;
  endfunction

  function automatic logic exp_tx();
    foreach (q[i]) begin
      if (t >= q[i].pop && t < q[i].pop + FRAME) begin
        int k   = (t - q[i].pop) / CPB;
        int pos = k % 10;
        int b   = (k < 10) ? (160 + int'(q[i].s) / 256) : (int'(q[i].s) % 256);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return logic'((b >> (pos - 1)) & 1);
      end
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    t++;
    if (rst) begin
      q.delete();
      last_pop = -1000000;
      prev_stb = 1'b1;
      m_ovf    = 1'b0;
    end else begin
      bit cap;
      cap = strobe && !prev_stb;
      prev_stb = strobe;
      if (cap) begin
        if (mod_level() >= DEPTH) m_ovf = 1'b1;
        else begin
          int p;
          p = (t + 1 > last_pop + FRAME) ? t + 1 : last_pop + FRAME;
          q.push_back('{p, sin});
          last_pop = p;
        end
      end
      while (q.size() > 0 && t >= q[0].pop + FRAME) void'(q.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("tx", tx, exp_tx());
    chk("busy", busy, (mod_level() != 0) || (exp_busy_inflight()));
    chk("level", lvl, mod_level());
    chk("overflow", ovf, m_ovf);
    if (int'(lvl) > peak) peak = int'(lvl);
  endtask

  function automatic bit exp_busy_inflight();
    foreach (q[i]) if (t >= q[i].pop && t < q[i].pop + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  // Waits for a start bit, then samples each bit mid-cell.
  task automatic rx_byte(output logic [7:0] b, output int waits);
    waits = 0;
    b = '0;
    while (tx !== 1'b0 && waits < 400) begin
      tick();
      waits++;
    end
    chk("rx_start_seen", waits < 400, 1);
    repeat (CPB + CPB / 2) tick();
    for (int i = 0; i < 8; i++) begin
      b[i] = tx;
      if (i < 7) repeat (CPB) tick();
    end
    repeat (CPB) tick();
    chk("rx_stop_bit", tx, 1);
  endtask

  task automatic rst_seq();
    rst = 1'b1;
    strobe = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct { logic [DW-1:0] s; int lvl; bit ovf; } vec_t;
  vec_t v3[6];

  initial begin
    #2ms;
    $display("FAIL watchdog t=%0d got=timeout expected=finish", t);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int w;
    int c;
    int target;

    v3[0] = '{10'h001, 1, 1'b0};
    v3[1] = '{10'h002, 1, 1'b0};
    v3[2] = '{10'h003, 2, 1'b0};
    v3[3] = '{10'h004, 3, 1'b0};
    v3[4] = '{10'h005, 4, 1'b0};
    v3[5] = '{10'h006, 4, 1'b1};

    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_level", lvl, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // single sample, latency and both bytes
    sin = 10'h2A5; strobe = 1'b1;
    tick();
    chk("t1_level", lvl, 1);
    chk("t1_tx_capture_edge", tx, 1);
    strobe = 1'b0;
    rx_byte(b, w);
    chk("t1_latency", w, 1);
    chk("t1_byte0", b, 8'hA2);
    rx_byte(b, w);
    chk("t1_byte1", b, 8'hA5);
    chk("t1_no_gap", w, CPB / 2);
    repeat (CPB / 2) tick();
    chk("t1_idle_busy", busy, 0);

    // strobe held high
    sin = 10'h3FF; strobe = 1'b1; peak = 0;
    repeat (50) tick();
    strobe = 1'b0;
    repeat (60) tick();
    chk("t2_peak_level", peak, 1);
    chk("t2_busy", busy, 0);

    // six captures two cycles apart, last one dropped
    for (int i = 0; i < 6; i++) begin
      sin = v3[i].s; strobe = 1'b1;
      tick();
      chk("t3_level", lvl, v3[i].lvl);
      chk("t3_ovf", ovf, v3[i].ovf);
      strobe = 1'b0;
      tick();
    end
    repeat (400) tick();
    chk("t3_ovf_sticky", ovf, 1);
    chk("t3_busy", busy, 0);
    rst_seq();
    tick();
    chk("t3_ovf_cleared", ovf, 0);

    // capture on the pop edge while full
    for (int i = 0; i < 5; i++) begin
      sin = 10'(10'h100 + i); strobe = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
    end
    chk("t4_full_before", lvl, 4);
    target = q[1].pop;
    while (t < target - 1) tick();
    sin = 10'h1EE; strobe = 1'b1;
    tick();
    chk("t4_level_kept", lvl, 4);
    chk("t4_no_ovf", ovf, 0);
    strobe = 1'b0;
    repeat (6 * FRAME) tick();
    chk("t4_drained", busy, 0);

    // reset during byte1 data bits
    sin = 10'h0C3; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    c = t;
    while (t < c + 50) tick();
    rst = 1'b1; strobe = 1'b1;
    tick();
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_level", lvl, 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("t5_held_no_capture", lvl, 0);
    strobe = 1'b0;
    tick();
    sin = 10'h02C; strobe = 1'b1;
    tick();
    chk("t5_recapture", lvl, 1);
    strobe = 1'b0;
    repeat (FRAME + 5) tick();

    // two queued samples, back to back
    sin = 10'h000; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    sin = 10'h155; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    rx_byte(b, w);
    chk("t6_b0", b, 8'hA0);
    rx_byte(b, w);
    chk("t6_b1", b, 8'h00);
    rx_byte(b, w);
    chk("t6_b2", b, 8'hA1);
    chk("t6_no_gap", w, CPB / 2);
    rx_byte(b, w);
    chk("t6_b3", b, 8'h55);
    repeat (CPB) tick();

    // random traffic against the timeline model
    rst_seq();
    for (int n = 0; n < 40; n++) begin
      sin = 10'($urandom);
      strobe = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      strobe = 1'b0;
      repeat ($urandom_range(1, 70)) tick();
    end
    repeat (5 * FRAME + 10) tick();
    chk("rand_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
